// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the fp_add arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_arb_pkg;

  localparam int RM_W = 3;  // rounding-mode field width seen by fp_add
  localparam int ID_W = 4;  // widest requester id (16 requesters)

  // Rounding modes, same encoding as the fp_add ROUND_* defines
  localparam logic [RM_W-1:0] ROUND_RTNE = 3'd0;
  localparam logic [RM_W-1:0] ROUND_RTZ  = 3'd1;
  localparam logic [RM_W-1:0] ROUND_RDN  = 3'd2;
  localparam logic [RM_W-1:0] ROUND_RUP  = 3'd3;
  localparam logic [RM_W-1:0] ROUND_RMM  = 3'd4;

  typedef struct packed {
    logic [31:0]     a;
    logic [31:0]     b;
    logic [RM_W-1:0] rm;
  } fp_req_t;

  typedef struct packed {
    logic [31:0]     data;
    logic [ID_W-1:0] id;
  } fp_rsp_t;

endpackage

// File: rtl/fp_add.sv
// Combinational IEEE-754 binary32 adder with selectable rounding mode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports in1/in2/round_type -> out.
module fp_add
  import fp_arb_pkg::*;
(
  input  logic [31:0]     in1,
  input  logic [31:0]     in2,
  input  logic [RM_W-1:0] round_type,
  output logic [31:0]     out
);

  logic        swap, sx, sy, eff_sub, inc, ovf_inf;
  logic        nan1, nan2, inf1, inf2;
  logic [7:0]  ex, ey, d;
  logic [22:0] fx, fy;
  logic [26:0] ax, ay0, ay, m;
  logic [27:0] sum;
  logic [9:0]  e, sh, ef;
  logic [4:0]  lz;
  logic [24:0] mr;

  always_comb begin
    // x is the operand of larger magnitude, so the aligned difference is never negative
    swap = in2[30:0] > in1[30:0];
    {sx, ex, fx} = swap ? in2 : in1;
    {sy, ey, fy} = swap ? in1 : in2;
    eff_sub = sx ^ sy;

    // 24-bit significand plus guard/round/sticky; subnormals use exponent 1 without hidden bit
    ax  = {(ex != 8'd0), fx, 3'b000};
    ay0 = {(ey != 8'd0), fy, 3'b000};
    d   = (ex == 8'd0 ? 8'd1 : ex) - (ey == 8'd0 ? 8'd1 : ey);
    if (d >= 8'd27) ay = {26'd0, |ay0};
    else            ay = (ay0 >> d) | {26'd0, |(ay0 & ((27'd1 << d) - 27'd1))};

    sum = eff_sub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
    e   = {2'b00, (ex == 8'd0 ? 8'd1 : ex)};

    lz = 5'd0;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);

    sh = 10'd0;
    if (sum[27]) begin
      m = {sum[27:2], sum[1] | sum[0]};
      e = e + 10'd1;
    end else begin
      // never normalise below exponent 1: what remains is a subnormal
      sh = ({5'd0, lz} < e - 10'd1) ? {5'd0, lz} : e - 10'd1;
      m  = sum[26:0] << sh;
      e  = e - sh;
    end

    case (round_type)
      ROUND_RTZ: inc = 1'b0;
      ROUND_RDN: inc = sx & (m[2] | (|m[1:0]));
      ROUND_RUP: inc = !sx & (m[2] | (|m[1:0]));
      ROUND_RMM: inc = m[2];
      default:   inc = m[2] & ((|m[1:0]) | m[3]);
    endcase

    mr = {1'b0, m[26:3]} + {24'd0, inc};
    if (mr[24])      ef = e + 10'd1;
    else if (mr[23]) ef = e;
    else             ef = 10'd0;
    out = {sx, ef[7:0], mr[24] ? mr[23:1] : mr[22:0]};

    ovf_inf = (round_type == ROUND_RTNE) || (round_type == ROUND_RMM) ||
              ((round_type == ROUND_RUP) && !sx) || ((round_type == ROUND_RDN) && sx);
    if (ef >= 10'd255) out = ovf_inf ? {sx, 8'hFF, 23'd0} : {sx, 8'hFE, 23'h7FFFFF};

    // exact cancellation gives +0, except -0 when rounding down
    if (sum == 28'd0) out = {eff_sub ? (round_type == ROUND_RDN) : sx, 31'd0};

    nan1 = (&in1[30:23]) & (|in1[22:0]);
    nan2 = (&in2[30:23]) & (|in2[22:0]);
    inf1 = (&in1[30:23]) & ~(|in1[22:0]);
    inf2 = (&in2[30:23]) & ~(|in2[22:0]);
    if (nan1 || nan2 || (inf1 && inf2 && (in1[31] ^ in2[31]))) out = 32'h7FC00000;
    else if (inf1 || inf2) out = inf1 ? in1 : in2;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
// Latency: grant is combinational; pointer updates on the clock after a grant.
// Backpressure: en=0 forces gnt=0 and holds the pointer.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] ptr;
  logic [IDW:0]   cand;
  logic           found;

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr+k modulo NREQ, which need not be a power of two
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (en && !found && req[cand[IDW-1:0]]) begin
        found  = 1'b1;
        gnt_id = cand[IDW-1:0];
      end
    end
    gnt = found ? (NREQ'(1) << gnt_id) : '0;
  end

  // a grant is always a handshake, since it requires req
  always_ff @(posedge clk) begin
    if (rst)        ptr <= '0;
    else if (found) ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one fp_add among NREQ requesters: round-robin grant, operand stage S1, result stage S2.
// Latency: accept in cycle T -> rsp_valid in T+2; one result per cycle sustained.
// Backpressure: S2 holds while rsp_valid & !rsp_ready; S1 fills only if empty or moving; req_ready all 0 when full.
// Ports: req_valid/req_ready/req_a/req_b/req_rm per requester; rsp_valid/rsp_ready/rsp_data/rsp_id; inflight = v1+v2.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int RW   = RM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*RW-1:0] req_rm,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic [1:0]         inflight
);

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            v1, v2, s1_adv, s2_adv, v1_nxt, v2_nxt;
  fp_req_t         s1_req;
  logic [ID_W-1:0] s1_id;
  fp_rsp_t         s2;
  logic [31:0]     add_out;

  assign s2_adv = !v2 || rsp_ready;
  assign s1_adv = !v1 || s2_adv;
  assign v2_nxt = s2_adv ? v1 : v2;
  assign v1_nxt = s1_adv ? |gnt : v1;

  assign req_ready = gnt;
  assign rsp_valid = v2;
  assign rsp_data  = s2.data;
  assign rsp_id    = s2.id[IDW-1:0];

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .en     (s1_adv),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  fp_add u_add (
    .in1        (s1_req.a),
    .in2        (s1_req.b),
    .round_type (s1_req.rm),
    .out        (add_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      s1_req   <= '0;
      s1_id    <= '0;
      s2       <= '0;
      inflight <= 2'd0;
    end else begin
      v1       <= v1_nxt;
      v2       <= v2_nxt;
      inflight <= {1'b0, v1_nxt} + {1'b0, v2_nxt};
      // payload registers move only with real data so idle cycles leave rsp_data untouched
      if (|gnt) begin
        s1_req <= '{a: req_a[gnt_id*32 +: 32], b: req_b[gnt_id*32 +: 32], rm: req_rm[gnt_id*RW +: RW]};
        s1_id  <= ID_W'(gnt_id);
      end
      if (s2_adv && v1) s2 <= '{data: add_out, id: s1_id};
    end
  end

  // ids wider than IDW are always zero-extended requester indices
  always_comb assert ({1'b0, s2.id} < (ID_W+1)'(NREQ));

endmodule
